fft_r22sdf_bitrev: RTL and testbench

- Output reorder stage for the R2²SDF FFT pipeline.
- The butterfly/twiddle chain emits each frame in bit-reversed order. This block buffers one frame and replays it in natural order.
- Ping-pong buffer of two N-entry banks per real/imag component. Sits between the last BFII stage and downstream spectral consumers.
- Sustains one sample per clock, continuous frames, no backpressure.

---
 rtl/fft_r22sdf_bitrev.sv | 183 ++++++++++++++++++
 tb/tb_fft_r22sdf_bitrev.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r22sdf_bitrev.sv
// Bit-reversed to natural-order frame reorder buffer for the R2^2SDF FFT output.
// Optional natural bin index output enabled by defining FFT_R22SDF_BITREV_INDEX_EN.
//
// Read FSM states:
//   state     | meaning
//   RD_IDLE   | no bank being replayed; start when the next bank in order is full
//   RD_ACTIVE | replaying bank rbank_q, one natural-order address per clock
module fft_r22sdf_bitrev #(
  parameter int DATA_WIDTH = 25,
  parameter int N          = 1024,
  localparam int LOG2N     = $clog2(N)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic                         sync_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic                         last_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o
`ifdef FFT_R22SDF_BITREV_INDEX_EN
  ,
  output logic [LOG2N-1:0]             index_o
`endif
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_e;

  logic [LOG2N-1:0]      wcnt;
  logic                  wbank;
  logic                  wr_started;
  logic [1:0]            full;
  logic                  wr_en;
  logic                  wr_done;
  logic [LOG2N-1:0]      waddr;

  logic [DATA_WIDTH-1:0] mem_re [0:2*N-1];
  logic [DATA_WIDTH-1:0] mem_im [0:2*N-1];

  rd_state_e             state_q, state_d;
  logic [LOG2N-1:0]      rcnt_q, rcnt_d;
  logic                  rbank_q, rbank_d;
  logic                  rd_en;
  logic                  rd_done;
  logic                  next_ready;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Sync sample always lands at address 0 of the current bank and restarts the frame.
  always_comb begin
    wr_en   = 1'b0;
    wr_done = 1'b0;
    waddr   = '0;
    if (valid_i && sync_i) begin
      wr_en = 1'b1;
    end else if (valid_i && wr_started) begin
      wr_en   = 1'b1;
      waddr   = bitrev(wcnt);
      wr_done = (wcnt == LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt       <= '0;
      wbank      <= 1'b0;
      wr_started <= 1'b0;
    end else if (valid_i && sync_i) begin
      wcnt       <= LOG2N'(1);
      wr_started <= 1'b1;
    end else if (wr_en) begin
      wcnt <= wcnt + LOG2N'(1);
      if (wr_done) begin
        wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_re[{wbank, waddr}] <= x_re_i;
      mem_im[{wbank, waddr}] <= x_im_i;
    end
  end

  // Write and read always address different banks, so set and clear never collide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full <= 2'b00;
    end else begin
      if (wr_done) begin
        full[wbank] <= 1'b1;
      end
      if (rd_done) begin
        full[rbank_q] <= 1'b0;
      end
    end
  end

  // A bank completing on the same edge the current replay ends still counts as ready.
  assign next_ready = full[~rbank_q] || (wr_done && (wbank != rbank_q));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    rd_en   = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full[rbank_q]) begin
          state_d = RD_ACTIVE;
          rcnt_d  = '0;
        end
      end
      RD_ACTIVE: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + LOG2N'(1);
        if (rcnt_q == LAST) begin
          rd_done = 1'b1;
          rbank_d = ~rbank_q;
          if (!next_ready) begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      z_re_o  <= '0;
      z_im_o  <= '0;
    end else begin
      valid_o <= rd_en;
      last_o  <= rd_done;
      if (rd_en) begin
        z_re_o <= mem_re[{rbank_q, rcnt_q}];
        z_im_o <= mem_im[{rbank_q, rcnt_q}];
      end
    end
  end

`ifdef FFT_R22SDF_BITREV_INDEX_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_o <= '0;
    end else if (rd_en) begin
      index_o <= rcnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_fft_r22sdf_bitrev.sv
// Self-checking bench for fft_r22sdf_bitrev: N=8 directed cases and an N=1024 random run,
// checked against a frame-level bit-reverse reference model.
`timescale 1ns/1ps
module tb_fft_r22sdf_bitrev;
  localparam int DW = 25;
  localparam int NS = 8;
  localparam int NL = 1024;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
    int            idx;
    int            t;
  } exp_t;

  typedef struct {
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;
    logic          exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic vs = 1'b0, ss = 1'b0;
  logic signed [DW-1:0] res = '0, ims = '0;
  logic vos, los;
  logic signed [DW-1:0] zrs, zis;
  logic vl = 1'b0, sl = 1'b0;
  logic signed [DW-1:0] rel = '0, iml = '0;
  logic vol, lol;
  logic signed [DW-1:0] zrl, zil;
`ifdef FFT_R22SDF_BITREV_INDEX_EN
  logic [2:0] idxs;
  logic [9:0] idxl;
`endif

  fft_r22sdf_bitrev #(.DATA_WIDTH(DW), .N(NS)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .valid_i(vs), .sync_i(ss), .x_re_i(res), .x_im_i(ims),
    .valid_o(vos), .last_o(los), .z_re_o(zrs), .z_im_o(zis)
`ifdef FFT_R22SDF_BITREV_INDEX_EN
    , .index_o(idxs)
`endif
  );

  fft_r22sdf_bitrev #(.DATA_WIDTH(DW), .N(NL)) u_dut_l (
    .clk_i(clk), .rst_i(rst), .valid_i(vl), .sync_i(sl), .x_re_i(rel), .x_im_i(iml),
    .valid_o(vol), .last_o(lol), .z_re_o(zrl), .z_im_o(zil)
`ifdef FFT_R22SDF_BITREV_INDEX_EN
    , .index_o(idxl)
`endif
  );

  // Reference model: collect each frame in arrival order, emit bin b = arrival slot bitrev(b).
  exp_t qs[$];
  exp_t ql[$];
  exp_t frs[NS];
  exp_t frl[NL];
  int   ms_cnt = 0, ml_cnt = 0;
  bit   ms_go = 1'b0, ml_go = 1'b0;

  function automatic int rev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) if (v[i]) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic send_s(input bit v, input bit s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge clk);
    vs = v; ss = s; res = re; ims = im;
    if (v) begin
      if (s) begin ms_go = 1'b1; ms_cnt = 0; end
      if (ms_go) begin
        frs[ms_cnt].re = re;
        frs[ms_cnt].im = im;
        ms_cnt++;
        if (ms_cnt == NS) begin
          for (int b = 0; b < NS; b++) begin
            exp_t e;
            e = frs[rev(b, 3)];
            e.last = (b == NS - 1);
            e.idx = b;
            e.t = cyc + 1;
            qs.push_back(e);
          end
          ms_cnt = 0;
        end
      end
    end
  endtask

  task automatic send_l(input bit v, input bit s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge clk);
    vl = v; sl = s; rel = re; iml = im;
    if (v) begin
      if (s) begin ml_go = 1'b1; ml_cnt = 0; end
      if (ml_go) begin
        frl[ml_cnt].re = re;
        frl[ml_cnt].im = im;
        ml_cnt++;
        if (ml_cnt == NL) begin
          for (int b = 0; b < NL; b++) begin
            exp_t e;
            e = frl[rev(b, 10)];
            e.last = (b == NL - 1);
            e.idx = b;
            e.t = cyc + 1;
            ql.push_back(e);
          end
          ml_cnt = 0;
        end
      end
    end
  endtask

  task automatic idle_s();
    @(negedge clk);
    vs = 1'b0; ss = 1'b0;
  endtask

  // Called at the negedge right after the edge that accepted the frame's last sample.
  task automatic expect_run_s(input string tag, input int n);
    @(negedge clk);
    chk({tag, "_no_early"}, 64'(vos), 64'(0));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 64'(vos), 64'(1));
    end
    @(negedge clk);
    chk({tag, "_end"}, 64'(vos), 64'(0));
    chk({tag, "_drained"}, 64'(qs.size()), 64'(0));
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic lo,
                           input logic [DW-1:0] zr, input logic [DW-1:0] zi);
    chk({tag, "_data"}, 64'({zr, zi}), 64'({e.re, e.im}));
    chk({tag, "_last"}, 64'(lo), 64'(e.last));
    chk({tag, "_latency"}, 64'(cyc - e.t), 64'(2 + e.idx));
  endtask

  initial begin : mon_s
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && vos) begin
        if (qs.size() == 0) chk("s_spurious_valid", 64'(vos), 64'(0));
        else begin
          e = qs.pop_front();
          check_out("s", e, los, zrs, zis);
`ifdef FFT_R22SDF_BITREV_INDEX_EN
          chk("s_index", 64'(idxs), 64'(e.idx));
`endif
        end
      end
    end
  end

  initial begin : mon_l
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && vol) begin
        if (ql.size() == 0) chk("l_spurious_valid", 64'(vol), 64'(0));
        else begin
          e = ql.pop_front();
          check_out("l", e, lol, zrl, zil);
`ifdef FFT_R22SDF_BITREV_INDEX_EN
          chk("l_index", 64'(idxl), 64'(e.idx));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t tv[NS];
    int   ord[NS];
    int   w, run;

    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int k = 0; k < NS; k++) begin
      tv[k].in_re    = DW'(ord[k]);
      tv[k].in_im    = DW'(-ord[k]);
      tv[k].exp_re   = DW'(k);
      tv[k].exp_im   = DW'(-k);
      tv[k].exp_last = (k == NS - 1);
    end

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(vos), 64'(0));
    chk("rst_last", 64'(los), 64'(0));
    chk("rst_data", 64'({zrs, zis}), 64'(0));
`ifdef FFT_R22SDF_BITREV_INDEX_EN
    chk("rst_index", 64'(idxs), 64'(0));
`endif
    rst = 1'b0;

    // Single frame from the vector table.
    for (int k = 0; k < NS; k++) send_s(1'b1, k == 0, tv[k].in_re, tv[k].in_im);
    idle_s();
    @(negedge clk);
    chk("t1_no_early", 64'(vos), 64'(0));
    for (int j = 0; j < NS; j++) begin
      @(negedge clk);
      chk("t1_valid", 64'(vos), 64'(1));
      chk("t1_re", 64'({zrs}), 64'(tv[j].exp_re));
      chk("t1_im", 64'({zis}), 64'(tv[j].exp_im));
      chk("t1_last", 64'(los), 64'(tv[j].exp_last));
`ifdef FFT_R22SDF_BITREV_INDEX_EN
      chk("t1_index", 64'(idxs), 64'(j));
`endif
    end
    @(negedge clk);
    chk("t1_end", 64'(vos), 64'(0));
    repeat (3) @(negedge clk);

    // Three back-to-back frames, valid held high.
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int k = 0; k < NS; k++) send_s(1'b1, k == 0, DW'($urandom), DW'($urandom));
        idle_s();
      end
      begin
        w = 0;
        run = 0;
        while (!vos && w < 60) begin @(negedge clk); w++; end
        chk("t2_started", 64'(w < 60), 64'(1));
        while (vos && run < 40) begin run++; @(negedge clk); end
        chk("t2_contiguous_run", 64'(run), 64'(24));
      end
    join
    chk("t2_drained", 64'(qs.size()), 64'(0));
    repeat (3) @(negedge clk);

    // valid_i toggling through the frame.
    for (int k = 0; k < 15; k++) send_s(k % 2 == 0, k == 0, DW'($urandom), DW'($urandom));
    idle_s();
    expect_run_s("t3", NS);

    // Partial frame abandoned by a fresh sync.
    for (int k = 0; k < 5; k++) send_s(1'b1, k == 0, DW'($urandom), DW'($urandom));
    for (int k = 0; k < NS; k++) send_s(1'b1, k == 0, DW'($urandom), DW'($urandom));
    idle_s();
    expect_run_s("t4", NS);
    repeat (3) @(negedge clk);

    // Asynchronous reset while bin 3 is on the output.
    for (int k = 0; k < NS; k++) send_s(1'b1, k == 0, DW'($urandom), DW'($urandom));
    idle_s();
    repeat (5) @(negedge clk);
    chk("t5_mid_valid", 64'(vos), 64'(1));
    #2;
    rst = 1'b1;
    qs.delete(); ql.delete();
    ms_go = 1'b0; ml_go = 1'b0; ms_cnt = 0; ml_cnt = 0;
    #1;
    chk("t5_rst_valid", 64'(vos), 64'(0));
    chk("t5_rst_last", 64'(los), 64'(0));
    chk("t5_rst_data", 64'({zrs, zis}), 64'(0));
`ifdef FFT_R22SDF_BITREV_INDEX_EN
    chk("t5_rst_index", 64'(idxs), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) send_s(1'b1, 1'b0, DW'($urandom), DW'($urandom));
    idle_s();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t5_quiet", 64'(vos), 64'(0));
    end
    for (int k = 0; k < NS; k++) send_s(1'b1, k == 0, DW'($urandom), DW'($urandom));
    idle_s();
    expect_run_s("t5_after", NS);

    // N=1024, ten continuous random frames.
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < NL; k++) send_l(1'b1, k == 0, DW'($urandom), DW'($urandom));
    @(negedge clk);
    vl = 1'b0; sl = 1'b0;
    w = 0;
    while (ql.size() > 0 && w < 1200) begin @(negedge clk); w++; end
    chk("t6_drained", 64'(ql.size()), 64'(0));
    @(negedge clk);
    chk("t6_end", 64'(vol), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
